// File: rtl/pipe_pkg.sv
// Shared types and field helpers for the pipeline hazard controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StLdUse = 2'd1,
      StFlush = 2'd2,
      StMwait = 2'd3
   } haz_state_e;

   localparam logic [3:0] LOAD_OP_DEF  = 4'b1000;
   localparam logic [3:0] ATYPE_OP_DEF = 4'b0000;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RA_MSB  = 11;
   localparam int unsigned RA_LSB  = 8;
   localparam int unsigned RB_MSB  = 7;
   localparam int unsigned RB_LSB  = 4;
   localparam int unsigned RC_MSB  = 3;
   localparam int unsigned RC_LSB  = 0;

   function automatic logic [3:0] f_opc(input logic [15:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] f_ra(input logic [15:0] instr);
      return instr[RA_MSB:RA_LSB];
   endfunction

   function automatic logic [3:0] f_rb(input logic [15:0] instr);
      return instr[RB_MSB:RB_LSB];
   endfunction

   function automatic logic [3:0] f_rc(input logic [15:0] instr);
      return instr[RC_MSB:RC_LSB];
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush controls out.
interface pipe_hazard_ctrl_if;

   logic [15:0] in_id_instr;
   logic [15:0] in_ex_instr;
   logic        in_ex_valid;
   logic        in_br_taken;
   logic        in_mem_busy;
   logic        out_haz;
   logic        out_pc_stall;
   logic        out_ifid_stall;
   logic        out_idex_stall;
   logic        out_pc_load;
   logic [1:0]  out_state;
   logic [15:0] out_stall_cnt;

   modport master (
      output in_id_instr, in_ex_instr, in_ex_valid, in_br_taken, in_mem_busy,
      input  out_haz, out_pc_stall, out_ifid_stall, out_idex_stall, out_pc_load,
      input  out_state, out_stall_cnt
   );

   modport slave (
      input  in_id_instr, in_ex_instr, in_ex_valid, in_br_taken, in_mem_busy,
      output out_haz, out_pc_stall, out_ifid_stall, out_idex_stall, out_pc_load,
      output out_state, out_stall_cnt
   );

endinterface

// File: rtl/haz_ld_use_det.sv
// Combinational load-use comparator: EX load destination against ID sources.
module haz_ld_use_det
   import pipe_pkg::*;
#(
   parameter logic [3:0] LOAD_OP  = LOAD_OP_DEF,
   parameter logic [3:0] ATYPE_OP = ATYPE_OP_DEF
) (
   input  logic [15:0] id_instr,
   input  logic [15:0] ex_instr,
   input  logic        ex_valid,
   output logic        ld_use
);

   logic [3:0] src2;

   always_comb begin
      // A-type reads RB as its second source; everything else reads RC.
      src2   = (f_opc(id_instr) == ATYPE_OP) ? f_rb(id_instr) : f_rc(id_instr);
      ld_use = ex_valid && (f_opc(ex_instr) == LOAD_OP) &&
               ((f_ra(ex_instr) == f_ra(id_instr)) || (f_ra(ex_instr) == src2));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller (load-use, branch flush, memory wait).
// Optional stall counter enabled by defining HAZ_STALL_CNT_EN.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter logic [3:0]  LOAD_OP   = LOAD_OP_DEF,
   parameter logic [3:0]  ATYPE_OP  = ATYPE_OP_DEF,
   parameter int unsigned FLUSH_CYC = 2
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave hif
);

   localparam logic [1:0] FlushInit = 2'(FLUSH_CYC - 1);

   haz_state_e state_q, state_d, saved_q, saved_d, cur_state, flush_next;
   logic [1:0] cnt_q, cnt_d;
   logic       ld_use;
   logic       haz, pc_stall;

   haz_ld_use_det #(
      .LOAD_OP (LOAD_OP),
      .ATYPE_OP(ATYPE_OP)
   ) u_det (
      .id_instr(hif.in_id_instr),
      .ex_instr(hif.in_ex_instr),
      .ex_valid(hif.in_ex_valid),
      .ld_use  (ld_use)
   );

   // LDUSE is a one-cycle decode of the RUN-cycle detect; the ID instruction is
   // re-evaluated next cycle, so the register itself only holds RUN/FLUSH/MWAIT.
   always_comb begin
      cur_state = state_q;
      if (state_q == StRun) begin
         if (hif.in_mem_busy) begin
            cur_state = StMwait;
         end else if (!hif.in_br_taken && ld_use) begin
            cur_state = StLdUse;
         end
      end
   end

   always_comb begin
      haz                = (cur_state == StLdUse) || (cur_state == StFlush);
      pc_stall           = (cur_state == StLdUse) || (cur_state == StMwait);
      hif.out_haz        = haz;
      hif.out_pc_stall   = pc_stall;
      hif.out_ifid_stall = pc_stall;
      hif.out_idex_stall = (cur_state == StMwait);
      hif.out_pc_load    = (state_q == StRun) && hif.in_br_taken && !hif.in_mem_busy;
      hif.out_state      = cur_state;
   end

   always_comb begin
      state_d    = state_q;
      saved_d    = saved_q;
      cnt_d      = cnt_q;
      flush_next = (cnt_q == 2'd0) ? StRun : StFlush;
      unique case (state_q)
         StRun: begin
            if (hif.in_mem_busy) begin
               state_d = StMwait;
               saved_d = StRun;
            end else if (hif.in_br_taken) begin
               state_d = StFlush;
               cnt_d   = FlushInit;
            end
         end
         StFlush: begin
            // The current bubble is already issued, so it counts even if a wait starts.
            if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
            if (hif.in_mem_busy) begin
               state_d = StMwait;
               saved_d = flush_next;
            end else begin
               state_d = flush_next;
            end
         end
         StMwait: begin
            if (!hif.in_mem_busy) state_d = saved_q;
         end
         StLdUse: state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         saved_q <= StRun;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
      end else if ((pc_stall || haz) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
   end

   assign hif.out_stall_cnt = stall_cnt_q;
`else
   assign hif.out_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cycle table plus randomized reference-model run.
module tb_pipe_hazard_ctrl;

   localparam int unsigned FlushCyc = 2;
   localparam logic [6:0] EIdle  = 7'b00000_00;
   localparam logic [6:0] ELdu   = 7'b11100_01;
   localparam logic [6:0] ELoad  = 7'b00001_00;
   localparam logic [6:0] EFlush = 7'b10000_10;
   localparam logic [6:0] EWait  = 7'b01110_11;

   typedef struct {
      logic        rst;
      logic [15:0] id;
      logic [15:0] ex;
      logic        valid;
      logic        br;
      logic        busy;
      logic [6:0]  exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   // Reference model: bubbles still owed, whether a memory wait is active, stall count.
   int m_flush;
   bit m_wait;
   int m_cnt;

   pipe_hazard_ctrl_if hif ();

   pipe_hazard_ctrl #(
      .FLUSH_CYC(FlushCyc)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hif(hif)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rs, input logic [15:0] id, input logic [15:0] ex,
                               input logic va, input logic br, input logic bu,
                               input logic [6:0] exp);
      vec_t t;
      t.rst = rs; t.id = id; t.ex = ex; t.valid = va; t.br = br; t.busy = bu; t.exp = exp;
      return t;
   endfunction

   function automatic bit ref_ldu(input logic [15:0] id, input logic [15:0] ex, input logic va);
      logic [3:0] s1, s2;
      s1 = id[11:8];
      s2 = (id[15:12] == 4'b0000) ? id[7:4] : id[3:0];
      return va && (ex[15:12] == 4'b1000) && ((ex[11:8] == s1) || (ex[11:8] == s2));
   endfunction

   function automatic logic [6:0] outs();
      return {hif.out_haz, hif.out_pc_stall, hif.out_ifid_stall, hif.out_idex_stall,
              hif.out_pc_load, hif.out_state};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst             = t.rst;
      hif.in_id_instr = t.id;
      hif.in_ex_instr = t.ex;
      hif.in_ex_valid = t.valid;
      hif.in_br_taken = t.br;
      hif.in_mem_busy = t.busy;
   endtask

   task automatic model_expect(input logic bu, input logic br, input logic ldu,
                               output logic [6:0] e);
      if (m_wait)            e = EWait;
      else if (m_flush > 0)  e = EFlush;
      else if (bu)           e = EWait;
      else if (br)           e = ELoad;
      else if (ldu)          e = ELdu;
      else                   e = EIdle;
   endtask

   task automatic model_step(input logic rs, input logic bu, input logic br, input logic [6:0] e);
      if (rs) begin
         m_flush = 0; m_wait = 0; m_cnt = 0;
      end else begin
         if ((e[6] || e[5]) && m_cnt < 65535) m_cnt++;
         if (m_wait) begin
            if (!bu) m_wait = 0;
         end else if (m_flush > 0) begin
            m_flush--;
            if (bu) m_wait = 1;
         end else if (bu) begin
            m_wait = 1;
         end else if (br) begin
            m_flush = FlushCyc;
         end
      end
   endtask

   initial begin
      vec_t        idle;
      logic [6:0]  e;
      logic [15:0] exp_cnt;
      logic [3:0]  op, rd, r1, r2, r3;

      idle = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, EIdle);

      vecs.push_back(idle);
      vecs.push_back(mk(0, 16'h0134, 16'h8300, 1, 0, 0, ELdu));
      vecs.push_back(idle);
      vecs.push_back(mk(0, 16'h0124, 16'h8300, 1, 0, 0, EIdle));
      vecs.push_back(mk(0, 16'h0134, 16'h8300, 0, 0, 0, EIdle));
      vecs.push_back(mk(0, 16'h5013, 16'h8300, 1, 0, 0, ELdu));
      vecs.push_back(mk(0, 16'h5030, 16'h8300, 1, 0, 0, EIdle));
      vecs.push_back(mk(0, 16'h0100, 16'h8000, 1, 0, 0, ELdu));
      // Branch: strobe, two bubbles (a second branch mid-flush is ignored), back to RUN.
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, ELoad));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EFlush));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, EFlush));
      vecs.push_back(idle);
      vecs.push_back(mk(0, 16'h0134, 16'h8300, 1, 1, 0, ELoad));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EFlush));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EFlush));
      vecs.push_back(idle);
      vecs.push_back(mk(0, 16'h0134, 16'h8300, 1, 1, 1, EWait));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EWait));
      vecs.push_back(idle);
      // Memory wait during the first flush bubble.
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, ELoad));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, EFlush));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, EWait));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, EWait));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EWait));
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, EFlush));
      vecs.push_back(idle);
      // Reset aborts a flush and a memory wait.
      vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, ELoad));
      vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, EFlush));
      vecs.push_back(idle);
      vecs.push_back(mk(0, 16'h0134, 16'h8300, 1, 0, 1, EWait));
      vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, EWait));
      vecs.push_back(idle);

      drive(idle);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
      end

`ifdef HAZ_STALL_CNT_EN
      @(negedge clk);
      drive(idle);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("cnt_reset", hif.out_stall_cnt, 16'd0);
      @(negedge clk);
      drive(mk(0, 16'h0134, 16'h8300, 1, 0, 0, ELdu));
      @(negedge clk);
      drive(idle);
      #1;
      check("cnt_ldu", hif.out_stall_cnt, 16'd1);
`endif

      // Randomized run against the reference model.
      @(negedge clk);
      drive(idle);
      rst = 1'b1;
      m_flush = 0; m_wait = 0; m_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         op = ($urandom_range(0, 1) == 1) ? 4'h8 : 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 3));
         r1 = 4'($urandom_range(0, 3));
         r2 = 4'($urandom_range(0, 3));
         r3 = 4'($urandom_range(0, 3));
         rst             = (c == 0) || ($urandom_range(0, 99) == 0);
         hif.in_ex_instr = {op, rd, 8'($urandom_range(0, 255))};
         hif.in_id_instr = {(($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15))),
                            r1, r2, r3};
         hif.in_ex_valid = ($urandom_range(0, 3) != 0);
         hif.in_br_taken = ($urandom_range(0, 7) == 0);
         hif.in_mem_busy = ($urandom_range(0, 5) == 0);
         #1;
         if (c > 0) begin
            model_expect(hif.in_mem_busy, hif.in_br_taken,
                         ref_ldu(hif.in_id_instr, hif.in_ex_instr, hif.in_ex_valid), e);
`ifdef HAZ_STALL_CNT_EN
            exp_cnt = 16'(m_cnt);
`else
            exp_cnt = 16'd0;
`endif
            check($sformatf("rand%0d_out", c), 16'(outs()), 16'(e));
            check($sformatf("rand%0d_cnt", c), hif.out_stall_cnt, exp_cnt);
         end else begin
            e = EIdle;
         end
         model_step(rst, hif.in_mem_busy, hif.in_br_taken, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 16-bit in-order processor. It sits beside the IF/ID/EX boundary and decides each cycle whether the front end advances, stalls or squashes. It drives the ID buffer's `in_haz` bubble input, the PC and IF/ID hold enables, and the PC redirect strobe. It handles load-use stalls, taken-branch flushes and multi-cycle memory waits with a small registered FSM.

## Interface
Parameters:
- `LOAD_OP`, 4'b1000: opcode (instr[15:12]) of a load; destination is instr[11:8].
- `ATYPE_OP`, 4'b0000: A-type opcode; sources are [11:8] and [7:4]. Every other opcode reads [11:8] and [3:0].
- `FLUSH_CYC`, 2: bubble cycles after a taken branch (1..3).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_id_instr`  in  16  instruction currently in ID.
- `in_ex_instr`  in  16  instruction currently in EX.
- `in_ex_valid`  in  1  EX holds a real, non-bubble instruction.
- `in_br_taken`  in  1  EX resolved a taken branch this cycle.
- `in_mem_busy`  in  1  data memory not ready; the pipeline must freeze.
- `out_haz`  out  1  bubble into ID buffer (drives `in_haz`).
- `out_pc_stall`  out  1  hold PC.
- `out_ifid_stall`  out  1  hold IF/ID register.
- `out_idex_stall`  out  1  hold ID/EX and later registers.
- `out_pc_load`  out  1  one-cycle strobe: load branch target into PC.
- `out_state`  out  2  current FSM state, for debug.
- `out_stall_cnt`  out  16  stall-cycle counter (only with `HAZ_STALL_CNT_EN`).

## Operation
- States: RUN=2'd0, LDUSE=2'd1, FLUSH=2'd2, MWAIT=2'd3.
- Load-use detect (combinational): `in_ex_valid` & ex opcode==`LOAD_OP` & ex[11:8] equals either ID source field per the ID opcode rule. Register 0 is not special.
- Priority each cycle in RUN: mem_busy > br_taken > load-use.
- RUN:
  - mem_busy → MWAIT.
  - br_taken → FLUSH; `out_pc_load`=1 this cycle; counter loaded with `FLUSH_CYC`-1.
  - load-use → LDUSE.
  - Otherwise stay in RUN; all outputs 0.
- LDUSE (1 cycle): `out_haz`=1, `out_pc_stall`=1, `out_ifid_stall`=1. Return to RUN unless mem_busy (→MWAIT) or br_taken (→FLUSH, pc_load=1).
- FLUSH:
  - `out_haz`=1 and PC/IF-ID not held.
  - Counter decrements; leave for RUN when it reaches 0.
  - mem_busy → MWAIT; the counter is retained and FLUSH resumes afterwards.
  - br_taken in FLUSH is ignored, since EX holds a bubble.
- MWAIT: all three stall outputs are 1 and `out_haz`=0. Leave when mem_busy=0, returning to the saved state (RUN or FLUSH). A load-use pending at entry is re-evaluated in RUN.
- Outputs are combinational decodes of state plus the RUN-cycle detect. `out_pc_load` is asserted only on the entry cycle.

## Timing
- Reset:
  - State RUN; counter and saved state cleared.
  - All outputs 0; `out_stall_cnt`=0.
  - Reset mid-FLUSH or mid-MWAIT aborts immediately.
- Load-use: stall asserted in the same cycle as detect; exactly 1 bubble cycle; ID re-evaluates next cycle.
- Taken branch: `out_pc_load` in cycle T; `out_haz`=1 in T+1..T+`FLUSH_CYC`.
- mem_busy takes effect the cycle it is high; resume the cycle after it drops.

## Configuration
- `HAZ_STALL_CNT_EN` defined: `out_stall_cnt` increments by 1 every cycle `out_pc_stall` or `out_haz` is 1. It saturates at 16'hFFFF and clears on `rst`.
- Not defined: the counter register is absent and `out_stall_cnt` is tied to 0.

## Structure
- Shared package `pipe_pkg`:
  - State encodings.
  - `LOAD_OP` and `ATYPE_OP` defaults.
  - Instruction field slice constants: OPC[15:12], RA[11:8], RB[7:4], RC[3:0].
- One sub-module, `haz_ld_use_det`: purely combinational load-use comparator, reused later for forwarding.

## Test plan
- Load-use: EX=16'h8300 (load to r3), valid; ID=16'h0134 (reads r3) → cycle T: haz=1, pc_stall=1, ifid_stall=1, state=LDUSE. T+1: RUN, all 0.
- No hazard: EX=16'h8300; ID=16'h0124 (reads r1,r2) → all outputs 0. Same stimulus with `in_ex_valid`=0 → all outputs 0.
- Branch: br_taken pulse at T, `FLUSH_CYC`=2 → pc_load=1 at T only; haz=1 at T+1,T+2; RUN at T+3.
- Simultaneous: br_taken and load-use at T → FLUSH wins, pc_load=1, no LDUSE. mem_busy also high → MWAIT, pc_load=0.
- MWAIT mid-flush: mem_busy high for 3 cycles during first FLUSH cycle → stalls=1 for 3 cycles, then the remaining 1 FLUSH bubble, then RUN.
- Reset in FLUSH: rst at T+1 → T+2: state=0, all outputs 0. With `HAZ_STALL_CNT_EN`, the counter reads 0 after reset and 1 after one LDUSE.
